half_word_assembler: RTL and testbench
======================================

// Module: half_word_assembler
// PURPOSE
//  Receive side of the split-word transfer: captures a 100-bit word delivered as two 50-bit halves
//  (lower first, then upper) on a shared half-bus. Reassembles the word, presents it on a
//  valid/ready output, and polices ordering and inter-half timeout. Sits between the timed
//  half-word sender and the wide-word consumer.
// PARAMETERS
//  HALF_W   50   width of one half; output word is 2*HALF_W
//  TIMEOUT  8    max cycles allowed from lower-half accept to upper-half accept (>=1)
//  CNT_W    $clog2(TIMEOUT+1)  timer width (derived, do not override)
// PORTS
//  clk        in   1         single clock, all logic on posedge
//  rst        in   1         synchronous, active-low reset
//  in_data    in   HALF_W    half-word payload
//  in_sel     in   1         0 = lower half, 1 = upper half
//  in_parity  in   1         even parity over in_data (used only with PARITY_CHK_EN)
//  in_valid   in   1         half-word present
//  in_ready   out  1         assembler can accept a half this cycle
//  b          out  2*HALF_W  assembled word {upper, lower}
//  b_valid    out  1         b holds a complete word
//  b_ready    in   1         consumer takes b
//  seq_err    out  1         1-cycle pulse: out-of-order half
//  tmo_err    out  1         1-cycle pulse: upper half missed deadline
//  par_err    out  1         1-cycle pulse: parity mismatch (0 without PARITY_CHK_EN)
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE, b=0, b_valid=0, timer=0, all err=0, lower reg=0.
//  Accept = in_valid & in_ready. in_ready = (state != FULL); combinational from state only.
//  States:
//   IDLE:    accept sel=0 -> store lower, timer=0, -> WAIT_HI.
//            accept sel=1 -> half dropped, seq_err pulse, stay IDLE.
//   WAIT_HI: accept sel=1 -> b <= {in_data, lower}, b_valid=1 next cycle, -> FULL.
//            accept sel=0 -> replace lower, timer=0, seq_err pulse, stay WAIT_HI.
//            no accept: timer++; if timer==TIMEOUT-1 -> discard lower, tmo_err pulse, -> IDLE.
//            Upper accepted on the same cycle the timer expires wins: no tmo_err, -> FULL.
//   FULL:    b_valid=1, b stable; in_ready=0. b_ready=1 -> b_valid=0, -> IDLE next cycle.
//  Latency: upper-half accept edge -> b_valid high after that edge (1 cycle). No same-cycle
//   bypass of FULL to a new lower half; a new lower half is taken one cycle after the handshake.
//  Deadline: lower accepted at edge T; upper accepted at any edge T+1..T+TIMEOUT is good;
//   none by T+TIMEOUT -> tmo_err high in the cycle after edge T+TIMEOUT, state IDLE.
//  b holds last assembled word after handshake (not cleared); only reset clears it.
//  Error pulses are registered, high exactly one cycle, independent of each other.
//  Reset mid-operation: partial lower half and pending b discarded, no error pulse.
//  Timer saturates; never wraps; width CNT_W covers TIMEOUT.
// CONFIGURATION
//  PARITY_CHK_EN defined: in IDLE/WAIT_HI, an accepted half with ^{in_data,in_parity}!=0 is
//   dropped (no state/timer/data change, no seq_err), par_err pulses; timer still advances.
//  PARITY_CHK_EN undefined: in_parity ignored, par_err tied 0, all halves treated as good.
// TESTING (TIMEOUT=8)
//  1 rst=0 2 cycles, release -> b=0, b_valid=0, in_ready=1, errs=0.
//  2 lower=0x...AAAA then upper=0x...5555 next cycle -> b={0x..5555,0x..AAAA}, b_valid 1 cycle
//    after upper; hold b_ready=0 5 cycles -> b stable, in_ready=0; b_ready=1 -> IDLE.
//  3 lower, then 8 idle cycles -> tmo_err 1 pulse, IDLE; upper at 8th edge instead -> FULL, no tmo_err.
//  4 upper in IDLE -> seq_err, dropped; lower,lower(new),upper -> seq_err once, b uses 2nd lower.
//  5 lower accepted, rst=0 for 1 cycle, upper -> seq_err, b_valid stays 0, b=0.
//  6 PARITY_CHK_EN: upper with bad parity -> par_err, still WAIT_HI; good upper -> FULL.

Source files
------------

// File: rtl/half_word_assembler_if.sv
// Bus bundle for the half-word assembler: half-word input side, wide-word output side, error pulses.
interface half_word_assembler_if #(
  parameter int HALF_W = 50
);
  logic [HALF_W-1:0]   in_data;
  logic                in_sel;
  logic                in_parity;
  logic                in_valid;
  logic                in_ready;
  logic [2*HALF_W-1:0] b;
  logic                b_valid;
  logic                b_ready;
  logic                seq_err;
  logic                tmo_err;
  logic                par_err;

  modport master (
    output in_data, in_sel, in_parity, in_valid, b_ready,
    input  in_ready, b, b_valid, seq_err, tmo_err, par_err
  );

  modport slave (
    input  in_data, in_sel, in_parity, in_valid, b_ready,
    output in_ready, b, b_valid, seq_err, tmo_err, par_err
  );
endinterface

// File: rtl/half_word_assembler.sv
// Reassembles a 2*HALF_W word from lower/upper halves with ordering and timeout policing.
// Optional parity screening of incoming halves is enabled by defining PARITY_CHK_EN.
module half_word_assembler #(
  parameter  int HALF_W  = 50,
  parameter  int TIMEOUT = 8,
  localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input logic                   clk,
  input logic                   rst,
  half_word_assembler_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WAIT_HI, FULL} state_e;

  state_e              state_q, state_d;
  logic [HALF_W-1:0]   lower_q, lower_d;
  logic [2*HALF_W-1:0] b_q, b_d;
  logic [CNT_W-1:0]    timer_q, timer_d;
  logic                seq_q, seq_d, tmo_q, tmo_d, par_q, par_d;
  logic                acc, par_bad, good;

  assign acc = bus.in_valid && (state_q != FULL);

`ifdef PARITY_CHK_EN
  assign par_bad = ^{bus.in_data, bus.in_parity};
`else
  logic unused_parity;
  assign unused_parity = bus.in_parity;
  assign par_bad       = 1'b0;
`endif

  // A half failing parity is treated as if nothing arrived, apart from par_err.
  assign good = acc && !par_bad;

  always_comb begin
    state_d = state_q;
    lower_d = lower_q;
    b_d     = b_q;
    timer_d = timer_q;
    seq_d   = 1'b0;
    tmo_d   = 1'b0;
    par_d   = acc && par_bad;
    case (state_q)
      IDLE: begin
        if (good && !bus.in_sel) begin
          lower_d = bus.in_data;
          timer_d = '0;
          state_d = WAIT_HI;
        end else if (good) begin
          seq_d = 1'b1;
        end
      end
      WAIT_HI: begin
        if (good && bus.in_sel) begin
          b_d     = {bus.in_data, lower_q};
          timer_d = '0;
          state_d = FULL;
        end else if (good) begin
          lower_d = bus.in_data;
          timer_d = '0;
          seq_d   = 1'b1;
        end else if (timer_q == CNT_W'(TIMEOUT - 1)) begin
          lower_d = '0;
          timer_d = '0;
          tmo_d   = 1'b1;
          state_d = IDLE;
        end else if (timer_q < CNT_W'(TIMEOUT)) begin
          timer_d = timer_q + 1'b1;
        end
      end
      FULL: begin
        if (bus.b_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      lower_q <= '0;
      b_q     <= '0;
      timer_q <= '0;
      seq_q   <= 1'b0;
      tmo_q   <= 1'b0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lower_q <= lower_d;
      b_q     <= b_d;
      timer_q <= timer_d;
      seq_q   <= seq_d;
      tmo_q   <= tmo_d;
      par_q   <= par_d;
    end
  end

  assign bus.in_ready = (state_q != FULL);
  assign bus.b_valid  = (state_q == FULL);
  assign bus.b        = b_q;
  assign bus.seq_err  = seq_q;
  assign bus.tmo_err  = tmo_q;
  assign bus.par_err  = par_q;

endmodule

// File: tb/tb_half_word_assembler.sv
// Randomized plus directed bench for half_word_assembler against a transaction-level model.
module tb_half_word_assembler;
  localparam int HW  = 50;
  localparam int TMO = 8;
  localparam logic [HW-1:0] PAT_A = {25{2'b10}};
  localparam logic [HW-1:0] PAT_5 = {25{2'b01}};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  half_word_assembler_if #(.HALF_W(HW)) bus ();

  half_word_assembler #(.HALF_W(HW), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: pending lower half remembered with the edge number it arrived on.
  bit          m_full, m_have_lo;
  logic [HW-1:0]   m_lo;
  logic [2*HW-1:0] m_b;
  int          m_lo_edge, edge_n;
  bit          m_seq, m_tmo, m_par;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input bit rstn, input bit v, input bit sel, input logic [HW-1:0] d,
                     input bit bad_par, input bit br);
    bit acc, pok;
    @(negedge clk);
    rst           = rstn;
    bus.in_valid  = v;
    bus.in_sel    = sel;
    bus.in_data   = d;
    bus.in_parity = (^d) ^ bad_par;
    bus.b_ready   = br;
    #1 chk("in_ready", bus.in_ready, !m_full);
`ifdef PARITY_CHK_EN
    pok = !bad_par;
`else
    pok = 1'b1;
`endif
    edge_n++;
    acc   = v && !m_full;
    m_seq = 0; m_tmo = 0; m_par = 0;
    if (!rstn) begin
      m_full = 0; m_have_lo = 0; m_lo = '0; m_b = '0;
    end else if (m_full) begin
      if (br) m_full = 0;
    end else begin
      if (acc && !pok) m_par = 1;
      if (acc && pok && !sel) begin
        if (m_have_lo) m_seq = 1;
        m_have_lo = 1; m_lo = d; m_lo_edge = edge_n;
      end else if (acc && pok && sel) begin
        if (m_have_lo) begin
          m_b = {d, m_lo}; m_full = 1; m_have_lo = 0;
        end else m_seq = 1;
      end else if (m_have_lo && (edge_n - m_lo_edge >= TMO)) begin
        m_have_lo = 0; m_tmo = 1;
      end
    end
    @(posedge clk);
    #1;
    chk("b", bus.b, m_b);
    chk("b_valid", bus.b_valid, m_full);
    chk("seq_err", bus.seq_err, m_seq);
    chk("tmo_err", bus.tmo_err, m_tmo);
    chk("par_err", bus.par_err, m_par);
  endtask

  task automatic idle(input int n, input bit br);
    for (int k = 0; k < n; k++) cyc(1, 0, 0, '0, 0, br);
  endtask

  initial begin
    bus.in_valid = 0; bus.in_sel = 0; bus.in_data = '0; bus.in_parity = 0; bus.b_ready = 0;
    m_full = 0; m_have_lo = 0; m_lo = '0; m_b = '0; m_lo_edge = 0; edge_n = 0;

    // reset and idle state
    cyc(0, 0, 0, '0, 0, 0);
    cyc(0, 0, 0, '0, 0, 0);
    idle(1, 0);
    chk("rst_b", bus.b, '0);
    chk("rst_in_ready", bus.in_ready, 1);

    // basic assembly, backpressure, release
    cyc(1, 1, 0, PAT_A, 0, 0);
    cyc(1, 1, 1, PAT_5, 0, 0);
    chk("asm_word", bus.b, {PAT_5, PAT_A});
    for (int k = 0; k < 5; k++) cyc(1, 1, 0, PAT_5, 0, 0);
    cyc(1, 0, 0, '0, 0, 1);
    idle(1, 0);

    // timeout, then upper exactly at the deadline edge
    cyc(1, 1, 0, PAT_A, 0, 0);
    idle(TMO, 0);
    cyc(1, 1, 0, PAT_5, 0, 0);
    idle(TMO - 1, 0);
    cyc(1, 1, 1, PAT_A, 0, 0);
    chk("deadline_full", bus.b_valid, 1);
    cyc(1, 0, 0, '0, 0, 1);

    // ordering errors
    cyc(1, 1, 1, PAT_5, 0, 0);
    cyc(1, 1, 0, HW'(50'h1234), 0, 0);
    cyc(1, 1, 0, HW'(50'h5678), 0, 0);
    cyc(1, 1, 1, HW'(50'h9abc), 0, 0);
    chk("second_lower", bus.b, {HW'(50'h9abc), HW'(50'h5678)});
    cyc(1, 0, 0, '0, 0, 1);

    // reset drops a pending lower half
    cyc(1, 1, 0, PAT_A, 0, 0);
    cyc(0, 0, 0, '0, 0, 0);
    cyc(1, 1, 1, PAT_5, 0, 0);
    chk("rst_mid_b", bus.b, '0);

    // bad-parity upper is dropped (only with parity checking)
    cyc(1, 1, 0, PAT_A, 0, 0);
    cyc(1, 1, 1, PAT_5, 1, 0);
    cyc(1, 1, 1, PAT_5, 0, 0);
    cyc(1, 0, 0, '0, 0, 1);

    // random traffic with alternating dense/sparse phases
    for (int i = 0; i < 3000; i++) begin
      int vp;
      vp = ((i / 150) % 3 == 0) ? 10 : 75;
      cyc(($urandom_range(99) >= 2), ($urandom_range(99) < vp), $urandom_range(1),
          HW'({$urandom(), $urandom()}), ($urandom_range(9) == 0), ($urandom_range(99) < 40));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
